fetch_unit: RTL and testbench

//   IF stage: owns the PC, issues instruction-memory fetches and presents one fetched

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// presents the fetched (pc, word) pair to the IF/ID register. A request made
// stale by a redirect is drained and its data dropped.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid
);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] req_addr;
   logic        consume;
   logic        ack_taken;
   logic        capture;

   assign consume   = if_valid & pc_write;
   // An ack only counts when a request is actually on the bus.
   assign ack_taken = imem_req & imem_ack;
   // Drained data and data arriving alongside a redirect are wrong-path.
   assign capture   = ack_taken & ~redirect & (state != DRAIN);

   // Request outputs and next state of the fetch FSM.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc;
      state_nxt = state;
      case (state)
         IDLE: begin
            imem_req  = ~redirect & (~if_valid | pc_write);
            imem_addr = pc;
            if (imem_req & ~imem_ack & ~rst)
               state_nxt = WAIT;
         end
         WAIT: begin
            imem_req  = 1'b1;
            imem_addr = req_addr;
            if (imem_ack)
               state_nxt = IDLE;
            else if (redirect)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = req_addr;
            if (imem_ack)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (rst)
         imem_req = 1'b0;
   end

   // FSM state register; reset abandons any outstanding request.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // PC, held request address and the presented instruction buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         if_pc    <= 32'h0;
         if_instr <= 32'h0;
         if_valid <= 1'b0;
      end else begin
         if (state == IDLE && imem_req && !imem_ack)
            req_addr <= pc;
         if (redirect) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
         end else if (capture) begin
            if_pc    <= imem_addr;
            if_instr <= imem_rdata;
            if_valid <= 1'b1;
            pc       <= imem_addr + 32'd4;
         end else if (consume) begin
            if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a small imem stand-in whose data
// word is a fixed function of the address.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        pc_write;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   int n_checks = 0;
   int n_fails  = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc(if_pc),
      .if_instr(if_instr), .if_valid(if_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = word_of(imem_addr);

   typedef struct {
      logic        rst;
      logic        pw;
      logic        rd;
      logic [31:0] rpc;
      logic        ack;
      logic        chk_if;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic pw, input logic rd, input logic [31:0] rpc,
                      input logic ack, input logic chk, input logic req, input logic [31:0] addr,
                      input logic vld, input logic [31:0] pc, input logic [31:0] ins);
      vec_t v;
      v.rst = r; v.pw = pw; v.rd = rd; v.rpc = rpc; v.ack = ack; v.chk_if = chk;
      v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_pc = pc; v.e_ins = ins;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, compare just after, then let the rising edge pass.
   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      rst = v.rst; pc_write = v.pw; redirect = v.rd; redirect_pc = v.rpc; imem_ack = v.ack;
      #1;
      check({tag, ".imem_req"}, {31'h0, imem_req}, {31'h0, v.e_req});
      if (v.e_req)
         check({tag, ".imem_addr"}, imem_addr, v.e_addr);
      if (v.chk_if) begin
         check({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, v.e_vld});
         check({tag, ".if_pc"}, if_pc, v.e_pc);
         check({tag, ".if_instr"}, if_instr, v.e_ins);
      end
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; pc_write = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;

      //   rst pw rd rpc            ack chk req addr           vld pc             instr
      add(1, 0, 0, 0,             0,  0,  0,  0,             0,  0,             0);
      add(1, 0, 0, 0,             0,  1,  0,  0,             0,  0,             0);
      // full rate, zero-latency acks
      add(0, 1, 0, 0,             1,  1,  1,  32'h0,         0,  0,             0);
      add(0, 1, 0, 0,             1,  1,  1,  32'h4,         1,  32'h0,         word_of(32'h0));
      add(0, 1, 0, 0,             1,  1,  1,  32'h8,         1,  32'h4,         word_of(32'h4));
      // stall: outputs hold, no request, stray acks ignored
      add(0, 0, 0, 0,             1,  1,  0,  0,             1,  32'h8,         word_of(32'h8));
      add(0, 0, 0, 0,             1,  1,  0,  0,             1,  32'h8,         word_of(32'h8));
      add(0, 0, 0, 0,             1,  1,  0,  0,             1,  32'h8,         word_of(32'h8));
      // release, then a 3-cycle latency fetch held through pc_write=0
      add(0, 1, 0, 0,             0,  1,  1,  32'hC,         1,  32'h8,         word_of(32'h8));
      add(0, 0, 0, 0,             0,  1,  1,  32'hC,         0,  32'h8,         word_of(32'h8));
      add(0, 0, 0, 0,             1,  1,  1,  32'hC,         0,  32'h8,         word_of(32'h8));
      add(0, 0, 0, 0,             0,  1,  0,  0,             1,  32'hC,         word_of(32'hC));
      // redirect while waiting: old address held until ack, data dropped
      add(0, 1, 0, 0,             0,  1,  1,  32'h10,        1,  32'hC,         word_of(32'hC));
      add(0, 1, 1, 32'h100,       0,  1,  1,  32'h10,        0,  32'hC,         word_of(32'hC));
      add(0, 1, 0, 0,             0,  1,  1,  32'h10,        0,  32'hC,         word_of(32'hC));
      add(0, 1, 0, 0,             1,  1,  1,  32'h10,        0,  32'hC,         word_of(32'hC));
      add(0, 1, 0, 0,             1,  1,  1,  32'h100,       0,  32'hC,         word_of(32'hC));
      // redirect in the same cycle as the ack of a waiting fetch
      add(0, 1, 0, 0,             0,  1,  1,  32'h104,       1,  32'h100,       word_of(32'h100));
      add(0, 1, 1, 32'h200,       1,  1,  1,  32'h104,       0,  32'h100,       word_of(32'h100));
      add(0, 1, 0, 0,             1,  1,  1,  32'h200,       0,  32'h100,       word_of(32'h100));
      // redirect in IDLE suppresses the request
      add(0, 1, 1, 32'h300,       1,  1,  0,  0,             1,  32'h200,       word_of(32'h200));
      add(0, 1, 0, 0,             1,  1,  1,  32'h300,       0,  32'h200,       word_of(32'h200));
      // redirect twice while draining; the newest target wins, ack still ends the drain
      add(0, 1, 0, 0,             0,  1,  1,  32'h304,       1,  32'h300,       word_of(32'h300));
      add(0, 1, 1, 32'h400,       0,  1,  1,  32'h304,       0,  32'h300,       word_of(32'h300));
      add(0, 1, 1, 32'hFFFF_FFFC, 1,  1,  1,  32'h304,       0,  32'h300,       word_of(32'h300));
      // PC wraps from the top of the address space
      add(0, 1, 0, 0,             1,  1,  1,  32'hFFFF_FFFC, 0,  32'h300,       word_of(32'h300));
      add(0, 1, 0, 0,             0,  1,  1,  32'h0,         1,  32'hFFFF_FFFC, word_of(32'hFFFF_FFFC));
      // reset while waiting
      add(1, 1, 0, 0,             0,  1,  0,  0,             0,  32'hFFFF_FFFC, word_of(32'hFFFF_FFFC));
      add(0, 1, 0, 0,             0,  1,  1,  32'h0,         0,  32'h0,         32'h0);
      add(0, 1, 0, 0,             1,  1,  1,  32'h0,         0,  32'h0,         32'h0);
      add(0, 0, 0, 0,             0,  1,  0,  0,             1,  32'h0,         word_of(32'h0));

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // Long-latency fetch of 0x4: request and address must hold every cycle.
      v.rst = 0; v.rd = 0; v.rpc = 0; v.chk_if = 0;
      v.pw = 1; v.ack = 0; v.e_req = 1; v.e_addr = 32'h4; v.e_vld = 0; v.e_pc = 0; v.e_ins = 0;
      step(v, "lat_issue");
      v.pw = 0;
      for (int k = 0; k < 4; k++)
         step(v, $sformatf("lat_hold%0d", k));
      v.ack = 1;
      step(v, "lat_ack");
      v.ack = 0; v.e_req = 0; v.chk_if = 1; v.e_vld = 1; v.e_pc = 32'h4; v.e_ins = word_of(32'h4);
      step(v, "lat_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
